// File: rtl/result_deskew.sv
// Output deskew stage for the systolic array's bottom-row partial sums. Each lane has its own
// delay chain, so a diagonal wavefront leaves as one aligned row. The stage also checks lane
// alignment, counts rows per tile, and supports a bypass mode that can only change between tiles.
module result_deskew #(
   parameter int unsigned PARTIAL_SUM_BW = 19,
   parameter int unsigned MATRIX_SIZE    = 8,
   parameter int unsigned SKEW_DIR       = 1,
   parameter int unsigned TILE_ROWS      = 8,
   parameter int unsigned OUT_REG        = 0,
   localparam int unsigned CW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  clr,
   input  logic                                  bypass,
   input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] data_in,
   input  logic [MATRIX_SIZE-1:0]                valid_in,
   output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] result_sync,
   output logic                                  out_valid,
   output logic                                  out_last,
   output logic [CW-1:0]                         row_cnt,
   output logic                                  tile_done,
   output logic                                  busy,
   output logic                                  align_err
);

   localparam int unsigned BW = PARTIAL_SUM_BW;
   localparam int unsigned N  = MATRIX_SIZE;
   localparam logic [CW-1:0] LastRow = CW'(TILE_ROWS - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e          state_q, state_d;
   logic            mode_byp_q, mode_byp_d;
   logic [N-1:0]    tap_valid, chain_busy, sel_valid;
   logic [BW*N-1:0] tap_data, sel_data;
   logic [CW-1:0]   row_cnt_q;
   logic            align_err_q, tile_done_q;
   logic            all_v, mis_v, last_beat, busy_c;

   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int unsigned D = (SKEW_DIR != 0) ? unsigned'(i) : (N - 1 - unsigned'(i));
      if (D == 0) begin : g_pass
         assign tap_valid[i]          = valid_in[i];
         assign tap_data[BW*i +: BW]  = data_in[BW*i +: BW];
         assign chain_busy[i]         = 1'b0;
      end else begin : g_chain
         logic [D-1:0]         vld_q;
         logic [D-1:0][BW-1:0] dat_q;

         // Shift {valid, data} one stage per cycle; the chain keeps shifting even in bypass
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               vld_q <= '0;
               dat_q <= '0;
            end else if (clr) begin
               vld_q <= '0;
               dat_q <= '0;
            end else begin
               vld_q[0] <= valid_in[i];
               dat_q[0] <= data_in[BW*i +: BW];
               for (int k = 1; k < D; k++) begin
                  vld_q[k] <= vld_q[k-1];
                  dat_q[k] <= dat_q[k-1];
               end
            end
         end

         assign tap_valid[i]         = vld_q[D-1];
         assign tap_data[BW*i +: BW] = dat_q[D-1];
         assign chain_busy[i]        = |vld_q;
      end
   end

   // In bypass every lane comes straight from its input; data is never gated by valid
   assign sel_valid = mode_byp_q ? valid_in : tap_valid;
   assign sel_data  = mode_byp_q ? data_in  : tap_data;
   assign all_v     = &sel_valid;
   assign mis_v     = (|sel_valid) && !all_v;
   assign last_beat = all_v && (row_cnt_q == LastRow);
   assign busy_c    = (state_q == StRun);

   // Next state and mode; mode only reloads while idle and not starting a tile, so a tile
   // never straddles a mode change
   always_comb begin
      state_d    = state_q;
      mode_byp_d = mode_byp_q;
      unique case (state_q)
         StIdle: begin
            if ((|valid_in) && !mode_byp_q) begin
               state_d = StRun;
            end else begin
               mode_byp_d = bypass;
            end
         end
         StRun: begin
            if (!(|chain_busy) && !(|valid_in)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (clr) begin
         state_d    = StIdle;
         mode_byp_d = bypass;
      end
   end

   // FSM state and effective mode registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         mode_byp_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_byp_q <= mode_byp_d;
      end
   end

   // Row counter, sticky alignment error and tile-done pulse; misaligned beats are not counted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_cnt_q   <= '0;
         align_err_q <= 1'b0;
         tile_done_q <= 1'b0;
      end else if (clr) begin
         row_cnt_q   <= '0;
         align_err_q <= 1'b0;
         tile_done_q <= 1'b0;
      end else begin
         if (all_v) begin
            row_cnt_q <= last_beat ? '0 : row_cnt_q + 1'b1;
         end
         if (mis_v) begin
            align_err_q <= 1'b1;
         end
         tile_done_q <= last_beat;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      // One extra register stage on every output, keeping their relative timing
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            result_sync <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            row_cnt     <= '0;
            tile_done   <= 1'b0;
            busy        <= 1'b0;
            align_err   <= 1'b0;
         end else begin
            result_sync <= sel_data;
            out_valid   <= all_v;
            out_last    <= last_beat;
            row_cnt     <= row_cnt_q;
            tile_done   <= tile_done_q;
            busy        <= busy_c;
            align_err   <= align_err_q;
         end
      end
   end else begin : g_out_comb
      assign result_sync = sel_data;
      assign out_valid   = all_v;
      assign out_last    = last_beat;
      assign row_cnt     = row_cnt_q;
      assign tile_done   = tile_done_q;
      assign busy        = busy_c;
      assign align_err   = align_err_q;
   end

endmodule

// File: tb/tb_result_deskew.sv
// Directed bench for result_deskew: a scoreboard queue holds each expected aligned row with the
// cycle it is due; every cycle both instances are checked against it.
module tb_result_deskew;

   localparam int unsigned BW = 19;
   localparam int unsigned N  = 4;
   localparam int unsigned W  = BW * N;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
      logic [1:0]   idx;
      int           due;
   } row_t;

   logic         clk  = 1'b0;
   logic         rstn = 1'b0;
   logic         clr  = 1'b0;
   logic         bypass = 1'b0;
   logic [W-1:0] din1 = '0, din2 = '0;
   logic [N-1:0] vin1 = '0, vin2 = '0;

   logic [W-1:0] rs1, rs2;
   logic         ov1, ol1, td1, bz1, ae1;
   logic         ov2, ol2, td2, bz2, ae2;
   logic [1:0]   rc1;
   logic [0:0]   rc2;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_n   = 0;
   row_t q1[$];
   row_t q2[$];
   row_t eb;
   bit   lastprev [1:2];
   bit   err_exp  [1:2];
   int   idx      [1:2];

   always #5 clk = ~clk;

   result_deskew #(
      .PARTIAL_SUM_BW(19), .MATRIX_SIZE(4), .SKEW_DIR(1), .TILE_ROWS(4), .OUT_REG(0)
   ) dut1 (
      .clk(clk), .rstn(rstn), .clr(clr), .bypass(bypass), .data_in(din1), .valid_in(vin1),
      .result_sync(rs1), .out_valid(ov1), .out_last(ol1), .row_cnt(rc1), .tile_done(td1),
      .busy(bz1), .align_err(ae1)
   );

   result_deskew #(
      .PARTIAL_SUM_BW(19), .MATRIX_SIZE(4), .SKEW_DIR(0), .TILE_ROWS(1), .OUT_REG(1)
   ) dut2 (
      .clk(clk), .rstn(rstn), .clr(clr), .bypass(bypass), .data_in(din2), .valid_in(vin2),
      .result_sync(rs2), .out_valid(ov2), .out_last(ol2), .row_cnt(rc2), .tile_done(td2),
      .busy(bz2), .align_err(ae2)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle check of one instance against its scoreboard
   task automatic mon(input int w);
      logic         ov, ol, td, ae;
      logic [W-1:0] rs;
      logic [1:0]   rc;
      row_t         e;
      bit           due;
      e   = '0;
      due = 1'b0;
      if (w == 1) begin
         ov = ov1; ol = ol1; td = td1; ae = ae1; rs = rs1; rc = rc1;
         if (q1.size() > 0 && q1[0].due == cyc_n) begin
            due = 1'b1;
            e   = q1.pop_front();
         end
      end else begin
         ov = ov2; ol = ol2; td = td2; ae = ae2; rs = rs2; rc = {1'b0, rc2};
         if (q2.size() > 0 && q2[0].due == cyc_n) begin
            due = 1'b1;
            e   = q2.pop_front();
         end
      end
      chk($sformatf("dut%0d c%0d out_valid", w, cyc_n), ov, due);
      if (due) begin
         chk($sformatf("dut%0d c%0d result_sync", w, cyc_n), rs, e.data);
         chk($sformatf("dut%0d c%0d out_last", w, cyc_n), ol, e.last);
         chk($sformatf("dut%0d c%0d row_cnt", w, cyc_n), rc, e.idx);
      end else begin
         chk($sformatf("dut%0d c%0d out_last idle", w, cyc_n), ol, 1'b0);
      end
      chk($sformatf("dut%0d c%0d tile_done", w, cyc_n), td, lastprev[w]);
      chk($sformatf("dut%0d c%0d align_err", w, cyc_n), ae, err_exp[w]);
      lastprev[w] = due && e.last;
   endtask

   task automatic cyc();
      #3;
      mon(1);
      mon(2);
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic settle();
      #2;
   endtask

   // Drive a skewed wavefront of 'rows' rows into instance w; optional late lane 2, bypass
   // request at step byp_at, and a one-cycle reset at step rst_at
   task automatic wave(input int w, input int rows, input int base, input bit late2,
                       input int byp_at, input int rst_at);
      logic [W-1:0] d;
      logic [N-1:0] v;
      row_t         e;
      int           r;
      for (int k = 0; k <= rows + 3; k++) begin
         d = '0;
         v = '0;
         for (int i = 0; i < N; i++) begin
            r = k - ((w == 1) ? (3 - i) : i) - ((late2 && i == 2) ? 1 : 0);
            if (r >= 0 && r < rows) begin
               v[i]            = 1'b1;
               d[BW*i +: BW]   = BW'(base + 100 * r + i);
            end
         end
         if (w == 1) begin
            din1 = d;
            vin1 = v;
         end else begin
            din2 = d;
            vin2 = v;
         end
         if (k == byp_at) bypass = 1'b1;
         if (k == 2) begin
            settle();
            chk($sformatf("dut%0d busy in tile", w), (w == 1) ? bz1 : bz2, 1'b1);
         end
         if (k == rst_at) begin
            rstn = 1'b0;
            q1.delete();
            lastprev[1] = 1'b0;
            err_exp[1]  = 1'b0;
            idx[1]      = 0;
            settle();
            chk("reset row_cnt", rc1, 2'd0);
            chk("reset result_sync", rs1, {{(W-BW){1'b0}}, d[BW-1:0]});
            chk("reset busy", bz1, 1'b0);
            chk("reset dut2 result_sync", rs2, '0);
         end else if (!late2 && k >= 3 && k - 3 < rows) begin
            e = '0;
            for (int i = 0; i < N; i++) e.data[BW*i +: BW] = BW'(base + 100 * (k - 3) + i);
            e.last = (w == 1) ? (idx[1] == 3) : 1'b1;
            e.idx  = 2'(idx[w]);
            e.due  = cyc_n + ((w == 1) ? 0 : 1);
            idx[w] = (w == 1) ? (idx[w] + 1) % 4 : 0;
            if (w == 1) q1.push_back(e);
            else q2.push_back(e);
         end
         cyc();
         if (late2 && k == 3) err_exp[w] = 1'b1;
         if (k == rst_at) begin
            rstn = 1'b1;
            break;
         end
      end
      if (w == 1) begin
         din1 = '0;
         vin1 = '0;
      end else begin
         din2 = '0;
         vin2 = '0;
      end
   endtask

   initial begin
      for (int w = 1; w <= 2; w++) begin
         lastprev[w] = 1'b0;
         err_exp[w]  = 1'b0;
         idx[w]      = 0;
      end
      @(posedge clk);
      #1;

      // Reset state: only the zero-delay lane follows its input
      din1 = {19'd4, 19'd3, 19'd2, 19'd1};
      settle();
      chk("reset lane0 passthrough", rs1, {{(W-BW){1'b0}}, 19'd1});
      chk("reset dut2 outputs", rs2, '0);
      chk("reset row_cnt", rc1, 2'd0);
      chk("reset busy dut1", bz1, 1'b0);
      chk("reset busy dut2", bz2, 1'b0);
      cyc();
      rstn = 1'b1;
      din1 = '0;
      cyc();
      cyc();

      // Full four-row tile, deskewed
      wave(1, 4, 0, 1'b0, -1, -1);
      settle();
      chk("busy falls after tile", bz1, 1'b0);
      cyc();
      cyc();

      // Bypass requested mid-tile: tile stays deskewed, bypass only once idle
      wave(1, 4, 1000, 1'b0, 2, -1);
      din1 = {19'd7004, 19'd7003, 19'd7002, 19'd7001};
      vin1 = '0;
      settle();
      chk("bypass busy fallen", bz1, 1'b0);
      chk("bypass not yet active", rs1, {{(W-BW){1'b0}}, 19'd7001});
      cyc();
      din1    = {19'd8004, 19'd8003, 19'd8002, 19'd8001};
      vin1    = '1;
      eb      = '0;
      eb.data = din1;
      eb.last = (idx[1] == 3);
      eb.idx  = 2'(idx[1]);
      eb.due  = cyc_n;
      idx[1]  = (idx[1] + 1) % 4;
      q1.push_back(eb);
      settle();
      chk("bypass zero delay", rs1, {19'd8004, 19'd8003, 19'd8002, 19'd8001});
      chk("bypass keeps idle", bz1, 1'b0);
      cyc();
      din1   = '0;
      vin1   = '0;
      bypass = 1'b0;
      clr    = 1'b1;
      cyc();
      clr         = 1'b0;
      idx[1]      = 0;
      lastprev[1] = 1'b0;
      cyc();

      // Lane 2 one cycle late: sticky error, bad beat not counted, clr clears it
      wave(1, 1, 2000, 1'b1, -1, -1);
      cyc();
      wave(1, 2, 3000, 1'b0, -1, -1);
      clr = 1'b1;
      cyc();
      clr         = 1'b0;
      err_exp[1]  = 1'b0;
      idx[1]      = 0;
      lastprev[1] = 1'b0;
      cyc();

      // Reset during row 2, then a fresh tile starts at row 0
      wave(1, 4, 4000, 1'b0, -1, 5);
      cyc();
      wave(1, 1, 5000, 1'b0, -1, -1);
      cyc();
      cyc();

      // Mirrored skew, registered outputs, one row per tile
      wave(2, 3, 6000, 1'b0, -1, -1);
      cyc();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
